// File: rtl/inscache_r32i.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : inscache_r32i
// Purpose  : Direct-mapped RV32I instruction cache. It refills one line
//            word-by-word over a req/ack memory port.
// Options  : INSCACHE_FLUSH_EN adds a Flush (fence.i) input that
//            invalidates every line.
// Revision : 1.0
//------------------------------------------------------------------------------
module inscache_r32i #(
  parameter int dataW = 32,
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
`ifdef INSCACHE_FLUSH_EN
  input  logic             Flush,
`endif
  input  logic             clock,
  input  logic             reset,
  input  logic [dataW-1:0] ProgAddr,
  output logic [dataW-1:0] Instruction,
  output logic             InsCacheStall,
  output logic             MemReq,
  output logic [dataW-1:0] MemAddr,
  input  logic             MemAck,
  input  logic [dataW-1:0] MemData
);

  localparam int c_WB = $clog2(WORDS);
  localparam int c_IB = $clog2(LINES);
  localparam int c_TB = dataW - 2 - c_WB - c_IB;
  localparam int c_LB = dataW - 2 - c_WB;  // line number = {tag, index}

  localparam logic [0:0] c_S_IDLE = 1'b0;
  localparam logic [0:0] c_S_FILL = 1'b1;

  logic [0:0]       r_state;
  logic [LINES-1:0] r_valid;
  logic [c_TB-1:0]  r_tag  [LINES];
  logic [dataW-1:0] r_data [LINES][WORDS];
  logic [c_WB-1:0]  r_cnt;
  logic [c_LB-1:0]  r_line;
  logic             r_flush_pend;

  logic [c_WB-1:0] w_word;
  logic [c_IB-1:0] w_idx;
  logic [c_TB-1:0] w_tag;
  logic [c_IB-1:0] w_fidx;
  logic [c_TB-1:0] w_ftag;
  logic            w_hit;
  logic            w_fill_ack;
  logic            w_last;
  logic            w_flush;
  logic            w_unused_offset;

`ifdef INSCACHE_FLUSH_EN
  assign w_flush = Flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_word          = ProgAddr[c_WB+1:2];
  assign w_idx           = ProgAddr[c_WB+c_IB+1:c_WB+2];
  assign w_tag           = ProgAddr[dataW-1:c_WB+c_IB+2];
  assign w_unused_offset = &{1'b0, ProgAddr[1:0]};

  // During a fill, index and tag come from the latched line, never ProgAddr.
  assign w_fidx = r_line[c_IB-1:0];
  assign w_ftag = r_line[c_LB-1:c_IB];

  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_fill_ack = (r_state == c_S_FILL) && MemAck;
  assign w_last     = (r_cnt == c_WB'(WORDS - 1));

  assign Instruction = r_data[w_idx][w_word];
  assign MemReq      = (r_state == c_S_FILL);
  assign MemAddr     = (r_state == c_S_FILL) ? {r_line, r_cnt, 2'b00} : '0;

  always_comb begin
    InsCacheStall = 1'b1;
    if (r_state == c_S_IDLE) begin
      InsCacheStall = !w_hit || w_flush || r_flush_pend;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= c_S_IDLE;
      r_valid      <= '0;
      r_cnt        <= '0;
      r_line       <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (w_flush || r_flush_pend) begin
            r_valid      <= '0;
            r_flush_pend <= 1'b0;
          end else if (!w_hit) begin
            r_line         <= ProgAddr[dataW-1:c_WB+2];
            r_cnt          <= '0;
            r_valid[w_idx] <= 1'b0;
            r_state        <= c_S_FILL;
          end
        end
        c_S_FILL: begin
          if (w_flush) begin
            r_flush_pend <= 1'b1;
          end
          if (MemAck) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_valid[w_fidx] <= 1'b1;
              r_state         <= c_S_IDLE;
            end
          end
        end
        default: r_state <= c_S_IDLE;
      endcase
    end
  end

  // Tag/data storage carries no reset; validity alone qualifies it.
  always_ff @(posedge clock) begin
    if (w_fill_ack) begin
      r_data[w_fidx][r_cnt] <= MemData;
      if (w_last) begin
        r_tag[w_fidx] <= w_ftag;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inscache_r32i.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_inscache_r32i
// Purpose  : Randomized fetch stream for inscache_r32i, scored against a
//            line-residency model of a direct-mapped cache.
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_inscache_r32i;

  localparam int LINES = 16;
  localparam int WORDS = 4;
  localparam int LINE_BYTES = 4 * WORDS;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ProgAddr;
  logic [31:0] Instruction;
  logic        InsCacheStall;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck;
  logic [31:0] MemData;
`ifdef INSCACHE_FLUSH_EN
  logic        Flush;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Model: which line base address each set currently holds.
  logic        m_valid [LINES];
  logic [31:0] m_base  [LINES];

  inscache_r32i #(.dataW(32), .LINES(LINES), .WORDS(WORDS)) dut (
`ifdef INSCACHE_FLUSH_EN
    .Flush         (Flush),
`endif
    .clock         (clock),
    .reset         (reset),
    .ProgAddr      (ProgAddr),
    .Instruction   (Instruction),
    .InsCacheStall (InsCacheStall),
    .MemReq        (MemReq),
    .MemAddr       (MemAddr),
    .MemAck        (MemAck),
    .MemData       (MemData)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hA5A5A5A5;
  endfunction

  function automatic logic [31:0] base_of(input logic [31:0] a);
    return a & ~32'(LINE_BYTES - 1);
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / LINE_BYTES) % LINES);
  endfunction

  function automatic bit resident(input logic [31:0] a);
    return m_valid[idx_of(a)] && (m_base[idx_of(a)] == base_of(a));
  endfunction

  task automatic clear_model();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic release_ctl();
    reset = 1'b0;
`ifdef INSCACHE_FLUSH_EN
    Flush = 1'b0;
`endif
  endtask

  // One fetch; on a miss, serve the refill with minw..maxw idle cycles per beat.
  task automatic fetch(input logic [31:0] addr, input int minw, input int maxw);
    int waits;
    int seen;
    int w;
    logic [31:0] base;
    @(negedge clock);
    release_ctl();
    ProgAddr = addr;
    MemAck   = 1'($urandom_range(0, 1));
    MemData  = $urandom;
    #1;
    if (resident(addr)) begin
      chk("hit_stall", 32'(InsCacheStall), 32'd0);
      chk("hit_instr", Instruction, mem_word(addr));
      chk("hit_req", 32'(MemReq), 32'd0);
      return;
    end
    chk("miss_stall", 32'(InsCacheStall), 32'd1);
    chk("miss_req", 32'(MemReq), 32'd0);
    base  = base_of(addr);
    waits = 0;
    seen  = 1;
    for (int k = 0; k < WORDS; k++) begin
      w = $urandom_range(maxw, minw);
      waits += w;
      for (int j = 0; j <= w; j++) begin
        @(negedge clock);
        MemAck  = (j == w);
        MemData = (j == w) ? mem_word(base + 32'(4 * k)) : $urandom;
        #1;
        chk("fill_stall", 32'(InsCacheStall), 32'd1);
        chk("fill_req", 32'(MemReq), 32'd1);
        chk("fill_addr", MemAddr, base + 32'(4 * k));
        if (InsCacheStall) seen++;
      end
    end
    m_valid[idx_of(addr)] = 1'b1;
    m_base[idx_of(addr)]  = base;
    @(negedge clock);
    MemAck = 1'b0;
    #1;
    chk("done_stall", 32'(InsCacheStall), 32'd0);
    chk("done_instr", Instruction, mem_word(addr));
    chk("done_req", 32'(MemReq), 32'd0);
    chk("stall_cycles", 32'(seen), 32'(1 + WORDS + waits));
  endtask

  // Start a fill of a non-resident address and hit it with reset on beat 'beat'.
  task automatic abort_fill(input logic [31:0] addr, input int beat);
    logic [31:0] base;
    base = base_of(addr);
    @(negedge clock);
    release_ctl();
    ProgAddr = addr;
    MemAck   = 1'b0;
    #1;
    chk("abort_miss", 32'(InsCacheStall), 32'd1);
    for (int k = 0; k <= beat; k++) begin
      @(negedge clock);
      MemAck  = 1'b1;
      MemData = mem_word(base + 32'(4 * k));
      if (k == beat) reset = 1'b1;
      #1;
      chk("abort_addr", MemAddr, base + 32'(4 * k));
    end
    @(negedge clock);
    MemAck = 1'b0;
    #1;
    chk("abort_req", 32'(MemReq), 32'd0);
    chk("abort_maddr", MemAddr, 32'd0);
    chk("abort_stall", 32'(InsCacheStall), 32'd1);
    clear_model();
  endtask

  initial begin
    logic [31:0] a;
    reset    = 1'b1;
    ProgAddr = 32'h0;
    MemAck   = 1'b0;
    MemData  = 32'h0;
`ifdef INSCACHE_FLUSH_EN
    Flush    = 1'b0;
`endif
    clear_model();
    repeat (2) @(negedge clock);
    #1;
    chk("rst_stall", 32'(InsCacheStall), 32'd1);
    chk("rst_req", 32'(MemReq), 32'd0);
    chk("rst_maddr", MemAddr, 32'd0);

    fetch(32'h0000_0000, 0, 0);
    fetch(32'h0000_0008, 0, 0);
    fetch(32'h0000_0100, 0, 0);
    fetch(32'h0000_0000, 0, 1);
    fetch(32'h0000_0040, 3, 3);
    fetch(32'h0000_0046, 0, 0);

    abort_fill(32'h0000_0080, 1);
    fetch(32'h0000_0040, 0, 0);
    abort_fill(32'h0000_0200, WORDS - 1);
    fetch(32'h0000_0200, 0, 1);

    for (int i = 0; i < 250; i++) begin
      a = ($urandom & 32'h0000_07FC) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = a | 32'h0010_0000;
      fetch(a, 0, 2);
    end

`ifdef INSCACHE_FLUSH_EN
    fetch(32'h0000_0000, 0, 0);
    @(negedge clock);
    ProgAddr = 32'h0000_0000;
    MemAck   = 1'b0;
    Flush    = 1'b1;
    #1;
    chk("flush_stall", 32'(InsCacheStall), 32'd1);
    clear_model();
    fetch(32'h0000_0000, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inscache_r32i.md
Name: inscache_r32i

Overview:
Direct-mapped instruction cache for the RV32I core. It sits between the PC module and instruction memory.
- Accepts the PC's ProgAddr and returns the 32-bit instruction combinationally on a hit.
- On a miss, asserts InsCacheStall, which holds the PC, while it refills one line from memory over a word-by-word req/ack handshake.

Parameters:
dataW, 32, data/address width (only 32 supported)
LINES, 16, number of cache lines (power of two, >=2)
WORDS, 4, 32-bit words per line (power of two, >=2)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
ProgAddr  input  dataW  fetch address from PC
Instruction  output  dataW  instruction word at ProgAddr (valid when InsCacheStall=0)
InsCacheStall  output  1  high while a miss is pending or a fill is in progress; drives PC stall
MemReq  output  1  read request to instruction memory
MemAddr  output  dataW  word address being requested (byte address, [1:0]=0)
MemAck  input  1  memory returns MemData for current MemAddr this cycle
MemData  input  dataW  read data, valid when MemAck=1

Behaviour:
- Address split: [1:0] ignored (treated as 0); word = next log2(WORDS) bits; index = next log2(LINES) bits; tag = remaining upper bits.
- Storage: flop arrays for valid[LINES], tag[LINES], data[LINES][WORDS]. Reads are asynchronous.
- hit = valid[index] && tag[index]==ProgAddr tag. Evaluated combinationally, so the stall is visible to the PC before the same edge.
- FSM states:
  - IDLE:
    - InsCacheStall = !hit; MemReq=0.
    - On miss: latch line base address (ProgAddr with word/offset bits cleared), clear word counter, go FILL.
  - FILL:
    - InsCacheStall=1; MemReq=1; MemAddr = base + 4*counter.
    - On MemAck: write MemData to data[index][counter] and increment counter.
    - On MemAck with counter==WORDS-1: write tag[index] and set valid[index]; go IDLE.
    - MemAck in IDLE is ignored.
- Miss penalty: 1 miss-detect edge + WORDS acked beats. The cycle after fill completion is a hit and InsCacheStall drops.
- Index, tag and base are taken from the latched fill address, not ProgAddr, during FILL.
- Instruction = data[index][word] of ProgAddr. Contents are don't-care when InsCacheStall=1.
- Replacement: the old line at the index is overwritten. valid[index] is cleared on entry to FILL, so a partial line is never reported as a hit.
- Memory may hold MemAck low indefinitely; MemReq/MemAddr stay stable until acked.
- Reset values:
  - state=IDLE, all valid=0, counter=0, MemReq=0, MemAddr=0.
  - InsCacheStall follows from hit and is 1 after reset, because everything misses.
  - Tag/data arrays need no reset.
- Reset mid-fill: abort next edge. MemReq=0, all valid=0; an in-flight ack is dropped. Memory side must tolerate a withdrawn request.
- Simultaneous final MemAck and reset: reset wins; line is not validated.

Optional Feature:
- Macro: INSCACHE_FLUSH_EN.
- When defined:
  - Adds input port Flush (1 bit, fence.i).
  - Flush=1 in IDLE clears all valid bits at the edge.
  - Flush=1 during FILL completes the fill, then clears all valid bits, including the new line, at the edge after fill completion.
  - InsCacheStall is forced high in any cycle where Flush=1.
- When undefined: no Flush port; valid bits clear only on reset.

Test Plan:
- Reset, ProgAddr=0x0, memory acks every cycle with data=addr^0xA5A5A5A5 -> InsCacheStall=1 for 5 cycles; MemAddr sequence 0x0,0x4,0x8,0xC; then Instruction=0xA5A5A5A5, stall=0.
- After fill of 0x0, ProgAddr=0x8 -> hit same cycle; Instruction=0xA5A5A5AD, MemReq stays 0.
- ProgAddr=0x100 (same index 0, LINES=16/WORDS=4) -> miss, refill 0x100..0x10C; then ProgAddr=0x0 misses again (conflict eviction).
- Memory stalls MemAck for 3 cycles per beat at ProgAddr=0x40 -> MemAddr held stable each beat; stall lasts 1+4*4=17 cycles; data correct.
- Reset asserted on the 2nd beat of a fill -> next cycle MemReq=0, state IDLE; ProgAddr=0x40 misses and refills from 0x40.
- With INSCACHE_FLUSH_EN: fill 0x0, pulse Flush -> stall high that cycle; next access to 0x0 misses and refetches.
